busyctr_multi: RTL

Multi-channel, runtime-configurable busy timer, the parametrised successor to the single fixed-length busy counter. Each of NCHAN independent channels holds off a downstream consumer for a programmable number of cycles after a start request, in one-shot, retrigger or periodic mode. It reports per-channel busy and expiry pulses for peripherals that need guaranteed quiet or hold-off intervals.

---
 rtl/busyctr_pkg.sv | 20 ++
 rtl/busyctr_multi_if.sv | 26 ++
 rtl/busyctr_chan.sv | 90 +++++++++
 rtl/busyctr_multi.sv | 54 +++++
 4 files changed

// File: rtl/busyctr_pkg.sv
// rtl/busyctr_pkg.sv - shared types and helpers for the multi-channel busy timer
//
// Purpose: mode encoding used by the configuration bus and every channel, plus
// the channel-index width helper shared by the interface and the top level.
// Ports: none (package).
package busyctr_pkg;

    typedef enum logic [1:0] {
        MODE_ONESHOT  = 2'd0,
        MODE_RETRIG   = 2'd1,
        MODE_PERIODIC = 2'd2,
        MODE_RESERVED = 2'd3
    } mode_t;

    // Channel index width; a single-channel build still needs a 1-bit index.
    function automatic int chan_idx_width(input int nchan);
        return (nchan > 1) ? $clog2(nchan) : 1;
    endfunction

endpackage

// File: rtl/busyctr_multi_if.sv
// rtl/busyctr_multi_if.sv - configuration write bus for the busy timer
//
// Purpose: groups the configuration write strobe, channel index, delay and mode.
// Signals:
//   cfg_wr     write strobe, one write per cycle it is high
//   cfg_chan   target channel index (CW bits); indices >= NCHAN are ignored
//   cfg_delay  delay D in cycles (WIDTH bits)
//   cfg_mode   mode to store (mode_t)
// Modports: master drives the bus, slave (the timer) receives it.
interface busyctr_multi_if
    import busyctr_pkg::*;
#(
    parameter int NCHAN = 4,
    parameter int WIDTH = 16
);
    localparam int CW = chan_idx_width(NCHAN);

    logic             cfg_wr;
    logic [CW-1:0]    cfg_chan;
    logic [WIDTH-1:0] cfg_delay;
    mode_t            cfg_mode;

    modport master (output cfg_wr, output cfg_chan, output cfg_delay, output cfg_mode);
    modport slave  (input  cfg_wr, input  cfg_chan, input  cfg_delay, input  cfg_mode);

endinterface

// File: rtl/busyctr_chan.sv
// rtl/busyctr_chan.sv - one busy-timer channel: counter, delay, mode, done pulse
//
// Purpose: holds off a consumer for D cycles after a start, in one-shot,
// retrigger or periodic mode.
// Ports:
//   i_clk, i_reset  clock, synchronous active-high reset
//   i_start         start request, level-sampled
//   i_abort         clears the counter without a done pulse
//   i_cfg_we        decoded write enable for this channel
//   i_cfg_delay     delay to latch on write
//   i_cfg_mode      mode to latch on write (reserved stored as one-shot)
//   o_busy          counter != 0
//   o_done          registered one-cycle pulse on natural expiry
module busyctr_chan
    import busyctr_pkg::*;
#(
    parameter int WIDTH         = 16,
    parameter int DEFAULT_DELAY = 22
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic             i_cfg_we,
    input  logic [WIDTH-1:0] i_cfg_delay,
    input  mode_t            i_cfg_mode,
    output logic             o_busy,
    output logic             o_done
);
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] dly_q, dly_d;
    mode_t            mode_q, mode_d;
    logic             done_q, done_d;

    logic cnt_zero;
    logic cnt_last;

    assign cnt_zero = (cnt_q == '0);
    assign cnt_last = (cnt_q == CNT_ONE);

    always_comb begin
        cnt_d  = cnt_q;
        done_d = 1'b0;
        dly_d  = dly_q;
        mode_d = mode_q;

        // Counter decisions always use the stored D/mode, so a same-cycle
        // configuration write only affects later loads and expiries.
        if (i_abort) begin
            cnt_d = '0;
        end else if (i_start && cnt_zero && (dly_q != '0)) begin
            cnt_d = dly_q;
        end else if (i_start && !cnt_zero && (mode_q == MODE_RETRIG)) begin
            // A retrigger at count 1 is a reload, not an expiry: no done.
            cnt_d = dly_q;
        end else if (cnt_last && (mode_q == MODE_PERIODIC)) begin
            // Auto-reload; D == 0 naturally lands on 0 and ends the run.
            cnt_d  = dly_q;
            done_d = 1'b1;
        end else if (!cnt_zero) begin
            cnt_d  = cnt_q - CNT_ONE;
            done_d = cnt_last;
        end

        if (i_cfg_we) begin
            dly_d  = i_cfg_delay;
            mode_d = (i_cfg_mode == MODE_RESERVED) ? MODE_ONESHOT : i_cfg_mode;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q  <= '0;
            dly_q  <= WIDTH'(DEFAULT_DELAY);
            mode_q <= MODE_ONESHOT;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            dly_q  <= dly_d;
            mode_q <= mode_d;
            done_q <= done_d;
        end
    end

    assign o_busy = !cnt_zero;
    assign o_done = done_q;

endmodule

// File: rtl/busyctr_multi.sv
// rtl/busyctr_multi.sv - multi-channel runtime-configurable busy timer (top)
//
// Purpose: NCHAN independent busy timers sharing one configuration write bus.
// Ports:
//   i_clk, i_reset  clock, synchronous active-high reset
//   i_start         per-channel start request (NCHAN)
//   i_abort         per-channel abort (NCHAN)
//   cfg             configuration write bus (slave modport)
//   o_busy          per-channel busy (NCHAN)
//   o_done          per-channel expiry pulse (NCHAN)
//   o_any_busy      OR of o_busy
module busyctr_multi
    import busyctr_pkg::*;
#(
    parameter int NCHAN         = 4,
    parameter int WIDTH         = 16,
    parameter int DEFAULT_DELAY = 22
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [NCHAN-1:0] i_start,
    input  logic [NCHAN-1:0] i_abort,
    busyctr_multi_if.slave   cfg,
    output logic [NCHAN-1:0] o_busy,
    output logic [NCHAN-1:0] o_done,
    output logic             o_any_busy
);
    localparam int CW = chan_idx_width(NCHAN);

    logic [NCHAN-1:0] cfg_we;

    for (genvar n = 0; n < NCHAN; n++) begin : g_chan
        // An index >= NCHAN matches no channel, so such writes are dropped.
        assign cfg_we[n] = cfg.cfg_wr && (cfg.cfg_chan == CW'(n));

        busyctr_chan #(
            .WIDTH         (WIDTH),
            .DEFAULT_DELAY (DEFAULT_DELAY)
        ) u_chan (
            .i_clk       (i_clk),
            .i_reset     (i_reset),
            .i_start     (i_start[n]),
            .i_abort     (i_abort[n]),
            .i_cfg_we    (cfg_we[n]),
            .i_cfg_delay (cfg.cfg_delay),
            .i_cfg_mode  (cfg.cfg_mode),
            .o_busy      (o_busy[n]),
            .o_done      (o_done[n])
        );
    end

    assign o_any_busy = |o_busy;

endmodule
